ip_dram_bridge: RTL
===================

// Module: ip_dram_bridge
// PURPOSE
//  Z80 I/O-port bridge to the DDR3 controller's 128-bit line interface; sits between the cZ80 bus and ip_sdram.
//  CPU loads a 27-bit word address and a 16-byte line buffer through I/O ports, then issues a line read or line write.
//  Completion is reported in a status port. The DRAM side is synchronous to clk; any CDC lives outside this block.
// PARAMETERS
//  IO_BASE         8'h10   base I/O address; the block decodes IO_BASE+0..IO_BASE+7 (IO_BASE[2:0] must be 0)
//  TIMEOUT_CYCLES  4096    read-wait watchdog limit; used only with IP_DRAM_BRIDGE_TIMEOUT_EN
// PORTS
//  clk              in   1    system clock; all logic on posedge
//  reset_n          in   1    asynchronous active-low reset
//  sdram_init_busy  in   1    1: DDR3 controller still initialising
//  bus_address      in   8    Z80 I/O address
//  bus_ioreq        in   1    1: I/O cycle
//  bus_write        in   1    1: write, 0: read
//  bus_valid        in   1    access request
//  bus_ready        out  1    1-cycle accept
//  bus_wdata        in   8    write data
//  bus_rdata        out  8    read data; 8'h00 whenever bus_rdata_en=0 (OR-bus)
//  bus_rdata_en     out  1    1-cycle read-data strobe
//  dram_address     out  27   [26:24] bank, [23:10] row, [9:0] column; [2:0] always 0
//  dram_write       out  1    1: line write, 0: line read
//  dram_valid       out  1    request; held until dram_ready
//  dram_ready       in   1    request accepted
//  dram_wdata       out  128  line data; byte n = bits [8n+7:8n]
//  dram_wdata_mask  out  16   1: byte n not written
//  dram_rdata       in   128  read line
//  dram_rdata_en    in   1    1-cycle read-line strobe
// BEHAVIOUR
//  Reset: all outputs 0; address reg 0; index 0; mask 16'hFFFF; line buffer 0; state IDLE.
//  Port map (offset from IO_BASE):
//   +0..+3  address bytes. +3 uses bits [2:0] only and reads back with [7:3]=0.
//   +4  byte index, 4 bits. Reads return {4'b0,index}.
//   +5  data window. Write: buf[index]<=wdata, mask[index]<=0, index++. Read: returns buf[index], index++. Index wraps 15->0.
//   +6  command, write-only. 8'h01=line read, 8'h02=line write, other values ignored. Reads return 8'h00.
//   +7  status, read-only: bit0 busy (state!=IDLE), bit1 sdram_init_busy, bit2 error. Reading clears error.
//  Handshake: accept when bus_valid & bus_ioreq & bus_address[7:3]==IO_BASE[7:3].
//   - bus_ready=1 for exactly that cycle.
//   - Reads: bus_rdata/bus_rdata_en valid on the following cycle, 1 cycle wide.
//   - Ports +0..+6 stall (bus_ready=0) while busy or sdram_init_busy. Port +7 is never stalled.
//  FSM:
//   IDLE    cmd 01/02 -> REQ
//   REQ     dram_valid=1, dram_write per cmd, address={addr[26:3],3'b000}
//           dram_ready -> WAIT_RD (read) or IDLE (write; mask<=16'hFFFF, index<=0)
//   WAIT_RD dram_rdata_en -> buf<=dram_rdata, index<=0 -> IDLE
//  Latency: command accept -> dram_valid on the next cycle.
//  dram_wdata/dram_address/dram_write stay stable while dram_valid=1.
//  Write command with mask==16'hFFFF is still issued; the DRAM writes nothing.
//  dram_rdata_en outside WAIT_RD is ignored. sdram_init_busy rising mid-operation does not abort the FSM.
// CONFIGURATION
//  IP_DRAM_BRIDGE_TIMEOUT_EN defined:
//   - WAIT_RD counts cycles. At TIMEOUT_CYCLES it returns to IDLE, sets error, leaves the buffer unchanged.
//   - A counter reset occurs on entering WAIT_RD.
//  Not defined: no counter; WAIT_RD waits indefinitely; status bit2 reads 0.
// TESTING
//  1 Reset, read +7 with sdram_init_busy=1 -> 8'h02; read +6 -> stalls until init_busy=0, then 8'h00.
//  2 Addr 07_ABCD_EF via +0..+3, 16 writes to +5 (00..0F), cmd 02 -> dram_address=27'h7ABCDE8, dram_write=1,
//    dram_wdata=128'h0F0E..0100, mask=16'h0000; dram_valid held across 3 cycles of dram_ready=0.
//  3 Index 4 via +4, write AA to +5, cmd 02 -> mask=16'hFFEF, byte 4 = AA; next write cmd -> mask=16'hFFFF.
//  4 Cmd 01, return dram_rdata=128'h0123..CDEF after 20 cycles -> +7 busy=1 until strobe.
//    16 reads of +5 -> EF,CD,..,23,01; 17th read -> EF (wrap).
//  5 Simultaneous: write to +0 while busy -> bus_ready=0 until IDLE, then address updated.
//    Read +7 while busy -> 8'h01 immediately.
//  6 (TIMEOUT_EN, TIMEOUT_CYCLES=16) cmd 01, no rdata_en -> IDLE after 16 cycles; +7 = 8'h04, then 8'h00.

Source files
------------

// File: rtl/ip_dram_bridge.sv
// ip_dram_bridge: Z80 I/O-port bridge to a 128-bit DRAM line interface.
// The CPU loads a 27-bit word address and a 16-byte line buffer through eight
// I/O ports, then issues a line read or line write. Status reports completion.
// Optional feature macro: IP_DRAM_BRIDGE_TIMEOUT_EN (read-wait watchdog and
// status error bit). When undefined, WAIT_RD waits indefinitely and the error
// bit reads 0.
module ip_dram_bridge #(
    parameter logic [7:0]  IO_BASE        = 8'h10,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sdram_init_busy,
    input  logic [7:0]   bus_address,
    input  logic         bus_ioreq,
    input  logic         bus_write,
    input  logic         bus_valid,
    output logic         bus_ready,
    input  logic [7:0]   bus_wdata,
    output logic [7:0]   bus_rdata,
    output logic         bus_rdata_en,
    output logic [26:0]  dram_address,
    output logic         dram_write,
    output logic         dram_valid,
    input  logic         dram_ready,
    output logic [127:0] dram_wdata,
    output logic [15:0]  dram_wdata_mask,
    input  logic [127:0] dram_rdata,
    input  logic         dram_rdata_en
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitRd} state_t;

    state_t           state_q, state_d;
    logic             cmd_wr_q, cmd_wr_d;
    logic [26:0]      addr_q, addr_d;
    logic [3:0]       idx_q, idx_d;
    logic [15:0]      mask_q, mask_d;
    logic [15:0][7:0] buf_q, buf_d;
    logic             err_q, err_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rdata_en_q, rdata_en_d;

`ifdef IP_DRAM_BRIDGE_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    logic       hit;
    logic       busy;
    logic       stall;
    logic       accept;
    logic [2:0] offset;

    assign offset = bus_address[2:0];
    assign busy   = (state_q != StIdle);
    assign hit    = bus_valid & bus_ioreq & (bus_address[7:3] == IO_BASE[7:3]);
    // Status port stays reachable so the CPU can poll while a line moves.
    assign stall  = (busy | sdram_init_busy) & (offset != 3'd7);
    assign accept = hit & ~stall;

    assign bus_ready       = accept;
    assign bus_rdata       = rdata_q;
    assign bus_rdata_en    = rdata_en_q;
    assign dram_valid      = (state_q == StReq);
    assign dram_write      = cmd_wr_q;
    assign dram_address    = {addr_q[26:3], 3'b000};
    assign dram_wdata      = buf_q;
    assign dram_wdata_mask = mask_q;

    // Next-state: bus port decode, then FSM (FSM error-set wins over status-read clear).
    always_comb begin
        state_d    = state_q;
        cmd_wr_d   = cmd_wr_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        mask_d     = mask_q;
        buf_d      = buf_q;
        err_d      = err_q;
        rdata_d    = 8'h00;
        rdata_en_d = 1'b0;
`ifdef IP_DRAM_BRIDGE_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        if (accept) begin
            if (bus_write) begin
                unique case (offset)
                    3'd0: addr_d[7:0]   = bus_wdata;
                    3'd1: addr_d[15:8]  = bus_wdata;
                    3'd2: addr_d[23:16] = bus_wdata;
                    3'd3: addr_d[26:24] = bus_wdata[2:0];
                    3'd4: idx_d         = bus_wdata[3:0];
                    3'd5: begin
                        buf_d[idx_q]  = bus_wdata;
                        mask_d[idx_q] = 1'b0;
                        idx_d         = idx_q + 4'd1;
                    end
                    3'd6: begin
                        if (bus_wdata == 8'h01) begin
                            state_d  = StReq;
                            cmd_wr_d = 1'b0;
                        end else if (bus_wdata == 8'h02) begin
                            state_d  = StReq;
                            cmd_wr_d = 1'b1;
                        end
                    end
                    3'd7: ;
                endcase
            end else begin
                rdata_en_d = 1'b1;
                unique case (offset)
                    3'd0: rdata_d = addr_q[7:0];
                    3'd1: rdata_d = addr_q[15:8];
                    3'd2: rdata_d = addr_q[23:16];
                    3'd3: rdata_d = {5'b00000, addr_q[26:24]};
                    3'd4: rdata_d = {4'b0000, idx_q};
                    3'd5: begin
                        rdata_d = buf_q[idx_q];
                        idx_d   = idx_q + 4'd1;
                    end
                    3'd6: rdata_d = 8'h00;
                    3'd7: begin
                        rdata_d = {5'b00000, err_q, sdram_init_busy, busy};
                        err_d   = 1'b0;
                    end
                endcase
            end
        end

        unique case (state_q)
            StIdle: ;
            StReq: begin
                if (dram_ready) begin
                    if (cmd_wr_q) begin
                        state_d = StIdle;
                        mask_d  = 16'hFFFF;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = StWaitRd;
`ifdef IP_DRAM_BRIDGE_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            StWaitRd: begin
                if (dram_rdata_en) begin
                    buf_d   = dram_rdata;
                    idx_d   = 4'd0;
                    state_d = StIdle;
                end
`ifdef IP_DRAM_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // State and register update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cmd_wr_q   <= 1'b0;
            addr_q     <= '0;
            idx_q      <= '0;
            mask_q     <= 16'hFFFF;
            buf_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            rdata_en_q <= 1'b0;
`ifdef IP_DRAM_BRIDGE_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_wr_q   <= cmd_wr_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            buf_q      <= buf_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            rdata_en_q <= rdata_en_d;
`ifdef IP_DRAM_BRIDGE_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

endmodule
